// File: rtl/fifo_rr_drain_arbiter.sv
// rtl/fifo_rr_drain_arbiter.sv - round-robin, packet-atomic drain of show-ahead FIFOs into one stream
//
// Purpose:
//   Drains NUM_PORTS show-ahead FIFOs, where q is valid whenever empty is low
//   and rdreq pops, into a single registered output with a valid/ready handshake.
//   A grant is held until the word flagged last has been popped. One IDLE
//   (arbitration) cycle separates consecutive grants.
//
// Optional feature (macro FIFO_ARB_BURST_LIMIT_EN):
//   When defined, a grant is also released after MAX_BURST pops, even mid-packet.
//   Packets from different ports may then interleave; out_port tells them apart.
//   When undefined, no burst counter exists and MAX_BURST has no effect.
//
// Ports:
//   clock      - single clock
//   reset_n    - asynchronous active-low reset
//   in_empty   - per-FIFO empty flag
//   in_q       - per-FIFO show-ahead data, port i at [i*WIDTH +: WIDTH]
//   in_last    - per-FIFO end-of-packet flag, aligned with in_q
//   in_rdreq   - per-FIFO pop strobe (combinational, one-hot or zero)
//   out_valid  - output register holds a word
//   out_data   - output word
//   out_last   - output word ends a packet
//   out_port   - source port of the output word
//   out_ready  - consumer accepts the word when out_valid && out_ready
//   busy       - arbiter is in GRANT

module fifo_rr_drain_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int WIDTH     = 32,
    parameter int MAX_BURST = 8
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [NUM_PORTS-1:0]         in_empty,
    input  logic [NUM_PORTS*WIDTH-1:0]   in_q,
    input  logic [NUM_PORTS-1:0]         in_last,
    output logic [NUM_PORTS-1:0]         in_rdreq,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_last,
    output logic [$clog2(NUM_PORTS)-1:0] out_port,
    input  logic                         out_ready,
    output logic                         busy
);

    localparam int PW = $clog2(NUM_PORTS);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   grant_q, grant_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic            out_last_q, out_last_d;
    logic [PW-1:0]   out_port_q, out_port_d;

    logic            sel_found;
    logic [PW-1:0]   sel_port;
    logic            pop;
    logic            release_grant;
    logic [WIDTH-1:0] grant_data;
    logic            grant_last;

`ifdef FIFO_ARB_BURST_LIMIT_EN
    logic [7:0]      burst_q, burst_d;
    logic            burst_hit;
`else
    localparam logic [7:0] unused_max_burst = 8'(MAX_BURST);
`endif

    // Round-robin search: walk downward from the farthest candidate so the
    // last hit recorded is the nearest non-empty port above rr_ptr.
    always_comb begin
        logic [PW-1:0] idx;
        sel_found = 1'b0;
        sel_port  = '0;
        idx       = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            idx = PW'((int'(rr_ptr_q) + k) % NUM_PORTS);
            if (!in_empty[idx]) begin
                sel_found = 1'b1;
                sel_port  = idx;
            end
        end
    end

    assign grant_data = in_q[int'(grant_q)*WIDTH +: WIDTH];
    assign grant_last = in_last[grant_q];

    // Pop whenever the output register is free or being emptied this cycle.
    assign pop = (state_q == GRANT) && !in_empty[grant_q] && (!out_valid_q || out_ready);

`ifdef FIFO_ARB_BURST_LIMIT_EN
    assign burst_hit     = (burst_q + 8'd1) == 8'(MAX_BURST);
    assign release_grant = pop && (grant_last || burst_hit);
`else
    assign release_grant = pop && grant_last;
`endif

    always_comb begin
        in_rdreq = '0;
        if (pop) begin
            in_rdreq[grant_q] = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
`ifdef FIFO_ARB_BURST_LIMIT_EN
        burst_d  = burst_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (sel_found) begin
                    grant_d = sel_port;
                    state_d = GRANT;
`ifdef FIFO_ARB_BURST_LIMIT_EN
                    burst_d = 8'd0;
`endif
                end
            end
            GRANT: begin
`ifdef FIFO_ARB_BURST_LIMIT_EN
                if (pop) begin
                    burst_d = burst_q + 8'd1;
                end
`endif
                // Releasing port becomes rr_ptr, so it has lowest priority next.
                if (release_grant) begin
                    rr_ptr_d = grant_q;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_port_d  = out_port_q;
        if (pop) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_data;
            out_last_d  = grant_last;
            out_port_d  = grant_q;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= PW'(NUM_PORTS - 1);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_port_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_port_q  <= out_port_d;
        end
    end

`ifdef FIFO_ARB_BURST_LIMIT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            burst_q <= 8'd0;
        end else begin
            burst_q <= burst_d;
        end
    end
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_port  = out_port_q;
    assign busy      = (state_q == GRANT);

endmodule

// File: tb/tb_fifo_rr_drain_arbiter.sv
// tb/tb_fifo_rr_drain_arbiter.sv - scoreboard bench for fifo_rr_drain_arbiter

module tb_fifo_rr_drain_arbiter;

    localparam int NP = 4;
    localparam int W  = 32;
`ifdef FIFO_ARB_BURST_LIMIT_EN
    localparam int MB = 4;
`else
    localparam int MB = 8;
`endif

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [NP-1:0] in_empty;
    logic [NP*W-1:0] in_q;
    logic [NP-1:0] in_last;
    logic [NP-1:0] in_rdreq;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_last;
    logic [1:0]    out_port;
    logic          out_ready = 1'b1;
    logic          busy;

    always #5 clock = ~clock;

    fifo_rr_drain_arbiter #(.NUM_PORTS(NP), .WIDTH(W), .MAX_BURST(MB)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_empty(in_empty), .in_q(in_q), .in_last(in_last), .in_rdreq(in_rdreq),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_port(out_port), .out_ready(out_ready), .busy(busy)
    );

    typedef struct packed {
        logic [1:0]  port;
        logic        last;
        logic [31:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [32:0] fq[NP][$];
    logic [3:0] log_q[$];
    int         total = 0;
    int         bad = 0;
    bit         sb_en = 1'b1;

    function automatic logic [31:0] word(input int p, input int n);
        return {p[7:0], n[23:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < NP; i++) begin
            if (fq[i].size() == 0) begin
                in_empty[i]        = 1'b1;
                in_q[i*W +: W]     = '0;
                in_last[i]         = 1'b0;
            end else begin
                in_empty[i]        = 1'b0;
                in_q[i*W +: W]     = fq[i][0][31:0];
                in_last[i]         = fq[i][0][32];
            end
        end
    endtask

    task automatic push_word(input int p, input int n, input bit last);
        fq[p].push_back({last, word(p, n)});
        refresh();
    endtask

    task automatic expect_word(input int p, input int n, input bit last);
        exp_t e;
        e.port = p[1:0];
        e.last = last;
        e.data = word(p, n);
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        int left = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clock);
            n++;
        end
        check(name, exp_q.size(), 0);
        repeat (2) @(posedge clock);
        #1;
        for (int i = 0; i < NP; i++) left += fq[i].size();
        check({name, "_fifos_empty"}, left, 0);
    endtask

    // FIFO model: show-ahead, popped on the edge where in_rdreq is sampled high.
    always @(posedge clock) begin
        logic [3:0] pr;
        pr = in_rdreq;
        log_q.push_back(pr);
        if (reset_n) check("rdreq_onehot0", $onehot0(pr), 1);
        #1;
        for (int i = 0; i < NP; i++) begin
            if (pr[i]) begin
                check("pop_nonempty", fq[i].size() != 0, 1);
                if (fq[i].size() != 0) void'(fq[i].pop_front());
            end
        end
        refresh();
    end

    // Scoreboard monitor: one comparison per accepted output word.
    always @(negedge clock) begin
        exp_t e;
        if (sb_en && reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word actual=%0h required=none", {out_port, out_last, out_data});
            end else begin
                e = exp_q.pop_front();
                check("sb_word", {out_port, out_last, out_data}, e);
            end
        end
    end

    logic [3:0] exp_log[13];
    int first8, pos_last1, cnt2, wait_n;

    initial begin
        refresh();
        #2;
        check("reset_outputs", {in_rdreq, out_valid, out_data, out_last, out_port, busy}, 0);
        @(posedge clock); #1;
        reset_n = 1'b1;

        // Idle: nothing to drain.
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            check("idle_quiet", {in_rdreq, out_valid, busy}, 0);
        end

        // Three 3-word packets, full rate, one dead cycle between grants.
        @(posedge clock); #1;
        log_q.delete();
        for (int p = 0; p < 3; p++)
            for (int n = 1; n <= 3; n++) begin
                push_word(p, n, n == 3);
                expect_word(p, n, n == 3);
            end
        wait_drain("rr_three_packets");
        exp_log = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd0, 4'd2, 4'd2, 4'd2, 4'd0, 4'd4, 4'd4, 4'd4, 4'd0};
        for (int i = 0; i < 13; i++) check("rr_rdreq_trace", log_q[i], exp_log[i]);

        // Grant held across an empty gap; port 3 waits for port 1's last.
        @(posedge clock); #1;
        log_q.delete();
        push_word(1, 1, 1'b0);
        expect_word(1, 1, 1'b0);
        @(posedge clock); #1;
        push_word(3, 1, 1'b1);
        repeat (5) @(posedge clock);
        #1;
        push_word(1, 2, 1'b1);
        expect_word(1, 2, 1'b1);
        expect_word(3, 1, 1'b1);
        wait_drain("gap_hold");
        first8 = -1; pos_last1 = -1; cnt2 = 0;
        for (int i = 0; i < log_q.size(); i++) begin
            if (log_q[i] == 4'd2) begin
                cnt2++;
                if (cnt2 == 2) pos_last1 = i;
            end
            if (log_q[i] == 4'd8 && first8 < 0) first8 = i;
        end
        check("gap_port3_after_last", (pos_last1 >= 0) && (first8 > pos_last1), 1);

        // Backpressure: output holds, no pop; pop in the cycle ready rises.
        @(posedge clock); #1;
        out_ready = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            push_word(0, n, n == 3);
            expect_word(0, n, n == 3);
        end
        @(posedge clock);
        @(posedge clock);
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            check("hold_stable", {out_valid, out_data, out_last, out_port, in_rdreq},
                  {1'b1, word(0, 1), 1'b0, 2'd0, 4'b0000});
        end
        @(posedge clock); #1;
        out_ready = 1'b1;
        #1;
        check("pop_on_ready_rise", in_rdreq, 4'b0001);
        wait_drain("hold_drain");

        // Wrap-around: port 3 releases, then ports 0 and 3 compete.
        @(posedge clock); #1;
        push_word(3, 1, 1'b1);
        expect_word(3, 1, 1'b1);
        wait_drain("wrap_first");
        push_word(0, 1, 1'b1);
        push_word(3, 2, 1'b1);
        expect_word(0, 1, 1'b1);
        expect_word(3, 2, 1'b1);
        wait_drain("wrap_second");

        // Long packet on port 0 against a short one on port 2.
        @(posedge clock); #1;
        for (int n = 1; n <= 10; n++) push_word(0, n, n == 10);
        for (int n = 1; n <= 2; n++) push_word(2, n, n == 2);
`ifdef FIFO_ARB_BURST_LIMIT_EN
        for (int n = 1; n <= 4; n++) expect_word(0, n, 1'b0);
        for (int n = 1; n <= 2; n++) expect_word(2, n, n == 2);
        for (int n = 5; n <= 10; n++) expect_word(0, n, n == 10);
`else
        for (int n = 1; n <= 10; n++) expect_word(0, n, n == 10);
        for (int n = 1; n <= 2; n++) expect_word(2, n, n == 2);
`endif
        wait_drain("burst_mix");

        // Reset in the middle of a granted packet.
        sb_en = 1'b0;
        @(posedge clock); #1;
        for (int n = 1; n <= 3; n++) push_word(1, n, n == 3);
        wait_n = 0;
        do begin
            @(negedge clock);
            wait_n++;
        end while (!(busy && out_valid) && wait_n < 50);
        check("midgrant_reached", busy && out_valid, 1);
        reset_n = 1'b0;
        #1;
        check("midgrant_reset_outputs", {in_rdreq, out_valid, out_data, out_last, out_port, busy}, 0);
        for (int i = 0; i < NP; i++) fq[i].delete();
        refresh();
        @(posedge clock); #1;
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        check("post_reset_idle", {in_rdreq, out_valid, busy}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_rr_drain_arbiter.md
Name: fifo_rr_drain_arbiter

Overview:
- Round-robin scheduler that drains NUM_PORTS show-ahead FIFO instances into one shared output stream.
- Packet-atomic: a grant is held until the word flagged last has been popped.
- Sits between per-requester FIFOs (lpm_showahead ON: q valid whenever empty is low, rdreq pops) and a single downstream consumer with a valid/ready handshake.

Parameters:
- NUM_PORTS, 4: number of requester FIFOs, 2..16.
- WIDTH, 32: data word width.
- MAX_BURST, 8: word limit per grant; used only with the optional feature. Range 1..255.

Ports:
- clock  in  1  Single clock for all logic.
- reset_n  in  1  Asynchronous active-low reset.
- in_empty  in  NUM_PORTS  Per-FIFO empty flag.
- in_q  in  NUM_PORTS*WIDTH  Per-FIFO show-ahead data; port i occupies bits [i*WIDTH +: WIDTH].
- in_last  in  NUM_PORTS  Per-FIFO end-of-packet flag, aligned with in_q.
- in_rdreq  out  NUM_PORTS  Per-FIFO pop strobe.
- out_valid  out  1  Output register holds a word.
- out_data  out  WIDTH  Output word.
- out_last  out  1  Output word ends a packet.
- out_port  out  $clog2(NUM_PORTS)  Source port of the output word.
- out_ready  in  1  Consumer accepts the word when out_valid && out_ready.
- busy  out  1  FSM is in GRANT.

Behaviour:
- Reset: asynchronous, active-low. All of the following clear immediately: state=IDLE, grant=0, rr_ptr=NUM_PORTS-1, burst count=0, out_valid=0, out_data=0, out_last=0, out_port=0, busy=0.
- in_rdreq is combinational, so it deasserts during reset.
- Reset mid-packet discards the packet in flight; upstream FIFOs are not flushed.
- FSM states:
  - IDLE: when any in_empty bit is low, select the first non-empty port searching upward from rr_ptr+1 with wrap-around (modulo NUM_PORTS). Register it as grant; go to GRANT next cycle. No pop in IDLE.
  - GRANT: busy=1. Pop condition: pop = ~in_empty[grant] && (~out_valid || out_ready). in_rdreq[grant] = pop; all other in_rdreq bits are 0.
  - in_rdreq is one-hot or zero in every cycle.
- Pop effect: on a pop, the output register loads in_q[grant], in_last[grant] and grant (into out_port) on the next edge, and out_valid=1.
- Latency: one cycle from pop to out_valid.
- Output hold: while out_valid && !out_ready, out_valid/out_data/out_last/out_port hold stable.
- Output clear: when out_valid && out_ready with no pop in the same cycle, out_valid clears.
- Throughput: full rate, one word per cycle, while the granted FIFO is non-empty and out_ready=1.
- Release: on the cycle a pop carries in_last[grant]=1:
  - rr_ptr<=grant;
  - state<=IDLE.
  - One dead cycle between grants.
- Granted FIFO empty mid-packet: hold the grant and wait. Other ports are not served; there is no timeout.
- Simultaneous requests: the lowest index after rr_ptr wins. A port that just released has the lowest priority in the next arbitration.
- Single active requester: re-granted every other cycle (IDLE/GRANT alternation).
- Fairness bound: a waiting non-empty port is granted within NUM_PORTS-1 packets of other ports.

Optional Feature:
- Macro: FIFO_ARB_BURST_LIMIT_EN.
- Defined: an 8-bit burst counter clears on entering GRANT and increments per pop.
  - Release also when a pop brings the count to MAX_BURST, even with in_last=0.
  - Release updates rr_ptr and returns to IDLE, exactly as a last-release.
  - Packets may interleave across ports; out_port identifies the source.
- Undefined: no counter is built; release occurs only on last. MAX_BURST is ignored.

Test Plan:
- Reset / idle:
  - All FIFOs empty for 20 cycles -> in_rdreq=0, out_valid=0, busy=0.
  - Reset asserted mid-GRANT -> every output is 0 within the same cycle.
- Ports 0,1,2 each hold a 3-word packet, out_ready=1 -> out_port sequence 0,0,0,1,1,1,2,2,2; out_last on words 3, 6 and 9; one idle cycle between packets.
- Port 1 holds 2 words (last on word 2) with a 5-cycle gap before word 2; port 3 non-empty throughout -> port 3 is not popped until port 1's last has been popped.
- out_ready held low for 4 cycles with out_valid=1 -> out_data is stable and in_rdreq=0 for those cycles; a word is popped in the same cycle out_ready rises.
- Port 3 released last; ports 0 and 3 both non-empty -> port 0 is granted next, via wrap-around.
- With FIFO_ARB_BURST_LIMIT_EN defined, MAX_BURST=4, port 0 holds a 10-word packet and port 2 a 2-word packet -> sequence: 4 words from port 0, 2 from port 2, 4 from port 0, 2 from port 0.
  - Without the macro, the same stimulus -> 10 words from port 0, then 2 from port 2.
